ins_fetch: RTL and testbench

//  Instruction Fetch stage; producer side of the IF/ID interface consumed by decode.

---
 rtl/ins_fetch_pkg.sv | 17 +
 rtl/ins_fetch_hold_buf.sv | 34 +++
 rtl/ins_fetch.sv | 193 +++++++++++++++++++
 tb/tb_ins_fetch.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ins_fetch_pkg.sv
// Shared fetch-stage definitions: instruction width, bubble encoding, PC increment.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package ins_fetch_pkg;

  localparam int ILEN = 32;

  // addi x0,x0,0 -- the canonical RISC-V NOP used as the IF/ID bubble.
  localparam logic [ILEN-1:0] NOP_ENC = 32'h0000_0013;

  // Sequential PC step. Plain 32-bit add: 32'hFFFF_FFFC wraps to 0 and the
  // low two bits pass through untouched (alignment is not this stage's job).
  function automatic logic [ILEN-1:0] pc_plus_4(input logic [ILEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/ins_fetch_hold_buf.sv
// Single-word capture register that parks a fetched instruction during a decode stall.
// Latency: captured word visible the cycle after cap.
// Backpressure: none; clr wins over cap, the owner decides when to capture or drop.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   cap, cap_dat       load cap_dat and mark the buffer valid
//   clr                invalidate the buffer (consumed or dropped by a redirect)
//   hold_dat, hold_vld buffered word and its valid flag
module ins_fetch_hold_buf
  import ins_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cap,
  input  logic            clr,
  input  logic [ILEN-1:0] cap_dat,
  output logic [ILEN-1:0] hold_dat,
  output logic            hold_vld
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_dat <= '0;
      hold_vld <= 1'b0;
    end else if (clr) begin
      hold_vld <= 1'b0;
    end else if (cap) begin
      hold_dat <= cap_dat;
      hold_vld <= 1'b1;
    end
  end

endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem request, fills IF/ID.
// Latency: accept at t, rvalid at t+1 -> IF/ID valid at t+2 (one instruction per 2 cycles).
// Backpressure: pipeline_stall freezes IF/ID; a word arriving under stall is parked until release.
//
// Optional feature macro: IFETCH_PERF_CNT_EN (adds perf_fetch_cnt_out / perf_stall_cnt_out).
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   pipeline_stall                decode hazard stall
//   ex_branch_taken/_target       one-cycle redirect from EX, beats stall and rvalid
//   imem_req/_addr/_gnt           request channel, address taken on req & gnt
//   imem_rvalid/_rdata            response channel
//   if_instruction_out, if_pc_out, if_pc_plus_4_out, if_valid_out   IF/ID buffer
//   perf_fetch_cnt_out            (macro) valid IF/ID loads, wraps
//   perf_stall_cnt_out            (macro) cycles with pipeline_stall high, wraps
module ins_fetch
  import ins_fetch_pkg::*;
#(
  parameter logic [ILEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [ILEN-1:0] NOP_INSTR = NOP_ENC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pipeline_stall,
  input  logic            ex_branch_taken,
  input  logic [ILEN-1:0] ex_branch_target,
  output logic            imem_req,
  output logic [ILEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic [ILEN-1:0] if_instruction_out,
  output logic [ILEN-1:0] if_pc_out,
  output logic [ILEN-1:0] if_pc_plus_4_out,
  output logic            if_valid_out
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_cnt_out,
  output logic [31:0]     perf_stall_cnt_out
`endif
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [ILEN-1:0] pc, pc_nxt;
  logic            discard, discard_nxt;

  logic            ifid_ld;
  logic            ifid_flush;
  logic [ILEN-1:0] ifid_src;
  logic            hold_cap;
  logic            hold_clr;
  logic [ILEN-1:0] hold_dat;
  logic            hold_vld;

  // Request is masked during reset so memory never sees a request from a
  // core that is not running yet.
  assign imem_req  = (state == S_REQ) && rst;
  assign imem_addr = pc;

  ins_fetch_hold_buf u_hold_buf (
    .clk      (clk),
    .rst_n    (rst),
    .cap      (hold_cap),
    .clr      (hold_clr),
    .cap_dat  (imem_rdata),
    .hold_dat (hold_dat),
    .hold_vld (hold_vld)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_REQ;
      pc      <= RESET_PC;
      discard <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      discard <= discard_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    discard_nxt = discard;
    ifid_ld     = 1'b0;
    ifid_flush  = 1'b0;
    ifid_src    = imem_rdata;
    hold_cap    = 1'b0;
    hold_clr    = 1'b0;

    case (state)
      S_REQ: begin
        if (ex_branch_taken) begin
          ifid_flush = 1'b1;
          pc_nxt     = ex_branch_target;
          // A request accepted in the redirect cycle fetched the old PC; its
          // response must be thrown away when it arrives.
          if (imem_gnt) begin
            discard_nxt = 1'b1;
            state_nxt   = S_WAIT;
          end
        end else if (imem_gnt) begin
          state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        if (ex_branch_taken) begin
          ifid_flush = 1'b1;
          pc_nxt     = ex_branch_target;
          if (imem_rvalid) begin
            discard_nxt = 1'b0;
            state_nxt   = S_REQ;
          end else begin
            discard_nxt = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (discard) begin
            discard_nxt = 1'b0;
            state_nxt   = S_REQ;
          end else if (pipeline_stall) begin
            hold_cap  = 1'b1;
            state_nxt = S_HOLD;
          end else begin
            ifid_ld   = 1'b1;
            pc_nxt    = pc_plus_4(pc);
            state_nxt = S_REQ;
          end
        end
      end

      S_HOLD: begin
        if (ex_branch_taken) begin
          ifid_flush = 1'b1;
          pc_nxt     = ex_branch_target;
          hold_clr   = 1'b1;
          state_nxt  = S_REQ;
        end else if (!pipeline_stall && hold_vld) begin
          ifid_ld   = 1'b1;
          ifid_src  = hold_dat;
          hold_clr  = 1'b1;
          pc_nxt    = pc_plus_4(pc);
          state_nxt = S_REQ;
        end
      end

      default: state_nxt = S_REQ;
    endcase
  end

  // IF/ID buffer. When decode is not stalled and nothing new arrives the
  // entry it just consumed becomes a bubble, so an instruction is never
  // presented twice; the PC fields are left as they were.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_instruction_out <= NOP_INSTR;
      if_pc_out          <= RESET_PC;
      if_pc_plus_4_out   <= pc_plus_4(RESET_PC);
      if_valid_out       <= 1'b0;
    end else if (ifid_flush) begin
      if_instruction_out <= NOP_INSTR;
      if_valid_out       <= 1'b0;
    end else if (ifid_ld) begin
      if_instruction_out <= ifid_src;
      if_pc_out          <= pc;
      if_pc_plus_4_out   <= pc_plus_4(pc);
      if_valid_out       <= 1'b1;
    end else if (!pipeline_stall) begin
      if_instruction_out <= NOP_INSTR;
      if_valid_out       <= 1'b0;
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt_out <= '0;
      perf_stall_cnt_out <= '0;
    end else begin
      if (ifid_ld)        perf_fetch_cnt_out <= perf_fetch_cnt_out + 32'd1;
      if (pipeline_stall) perf_stall_cnt_out <= perf_stall_cnt_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ins_fetch.sv
// Scoreboard bench for ins_fetch: directed stimulus, memory model, decode-side monitor.
// Latency: n/a.
// Backpressure: memory grants are metered by the stimulus; decode stall driven directly.
module tb_ins_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pipeline_stall = 1'b0;
  logic        ex_branch_taken = 1'b0;
  logic [31:0] ex_branch_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] if_instruction_out;
  logic [31:0] if_pc_out;
  logic [31:0] if_pc_plus_4_out;
  logic        if_valid_out;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  ins_fetch dut (
    .clk                (clk),
    .rst                (rst),
    .pipeline_stall     (pipeline_stall),
    .ex_branch_taken    (ex_branch_taken),
    .ex_branch_target   (ex_branch_target),
    .imem_req           (imem_req),
    .imem_addr          (imem_addr),
    .imem_gnt           (imem_gnt),
    .imem_rvalid        (imem_rvalid),
    .imem_rdata         (imem_rdata),
    .if_instruction_out (if_instruction_out),
    .if_pc_out          (if_pc_out),
    .if_pc_plus_4_out   (if_pc_plus_4_out),
    .if_valid_out       (if_valid_out)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt_out (perf_fetch_cnt),
    .perf_stall_cnt_out (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Expected IF/ID contents as {valid(32), instr, pc, pc+4}.
  logic [127:0] sbq[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] ifid();
    return {31'd0, if_valid_out, if_instruction_out, if_pc_out, if_pc_plus_4_out};
  endfunction

  function automatic logic [127:0] exp_ld(input logic [31:0] ins, input logic [31:0] pc,
                                          input logic [31:0] pc4);
    return {32'd1, ins, pc, pc4};
  endfunction

  // Hand-written instruction memory image.
  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h00A0_0113;
      32'h0000_0008: return 32'h0020_81B3;
      32'h0000_000C: return 32'h4011_0233;
      32'h0000_0100: return 32'h0000_0297;
      32'h0000_0104: return 32'h0042_8313;
      32'hFFFF_FFFC: return 32'h0000_006F;
      default:       return 32'hBAD0_0000;
    endcase
  endfunction

  // Memory model: drives 2 time units after each rising edge. A grant is
  // offered only while the stimulus has issued more grants than were used.
  int          lat = 1;
  int          grants_issued = 0;
  int          grants_used = 0;
  int          cd = 0;
  logic [31:0] paddr = 32'h0;

  always begin
    @(posedge clk);
    #2;
    if (!rst) begin
      cd          = 0;
      imem_rvalid = 1'b0;
      imem_gnt    = 1'b0;
    end else begin
      imem_rvalid = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = memf(paddr);
        end
      end
      imem_gnt = (grants_issued > grants_used);
      if (imem_req && imem_gnt) begin
        cd    = lat;
        paddr = imem_addr;
        grants_used++;
      end
    end
  end

  // Decode-side monitor: a valid IF/ID entry is consumed on any unstalled cycle.
  always @(negedge clk) begin
    if (rst && if_valid_out && !pipeline_stall) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got %h expected no instruction", ifid());
      end else begin
        chk("sb_ifid", ifid(), sbq.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Reset state
    step(2);
    chk("rst_ifid", ifid(), {32'd0, 32'h0000_0013, 32'h0, 32'h4});
    chk("rst_req", 128'(imem_req), 128'd0);
`ifdef IFETCH_PERF_CNT_EN
    chk("rst_perf", {64'd0, perf_fetch_cnt, perf_stall_cnt}, 128'd0);
`endif

    // 1: first fetch after reset release
    rst = 1'b1;
    grants_issued++;
    sbq.push_back(exp_ld(32'h0050_0093, 32'h0, 32'h4));
    #2;
    chk("t1_req", {imem_req, imem_addr}, {1'b1, 32'h0});
    step(3);
    chk("t1_next_addr", {imem_req, imem_addr}, {1'b1, 32'h4});

    // 2: stall across a fetch; word parks in HOLD, IF/ID frozen
    grants_issued += 2;
    sbq.push_back(exp_ld(32'h00A0_0113, 32'h4, 32'h8));
    sbq.push_back(exp_ld(32'h0020_81B3, 32'h8, 32'hC));
    step(2);
    pipeline_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("t2_stall_hold", ifid(), exp_ld(32'h00A0_0113, 32'h4, 32'h8));
    end
    chk("t2_hold_noreq", 128'(imem_req), 128'd0);
    pipeline_stall = 1'b0;
    step(2);

    // 3: redirect in WAIT, stale response arrives a cycle later
    lat = 2;
    grants_issued++;
    step(1);
    ex_branch_taken  = 1'b1;
    ex_branch_target = 32'h100;
    step(1);
    ex_branch_taken = 1'b0;
    chk("t3_flush", ifid(), {32'd0, 32'h0000_0013, 32'h8, 32'hC});
    chk("t3_wait_noreq", 128'(imem_req), 128'd0);
    step(1);
    chk("t3_new_addr", {imem_req, imem_addr}, {1'b1, 32'h100});
    lat = 1;
    grants_issued++;
    sbq.push_back(exp_ld(32'h0000_0297, 32'h100, 32'h104));
    step(3);

    // 4: redirect and stall together on a valid IF/ID entry
    grants_issued++;
    step(2);
    chk("t4_loaded", ifid(), exp_ld(32'h0042_8313, 32'h104, 32'h108));
    pipeline_stall   = 1'b1;
    ex_branch_taken  = 1'b1;
    ex_branch_target = 32'h200;
    step(1);
    pipeline_stall  = 1'b0;
    ex_branch_taken = 1'b0;
    chk("t4_flush", {if_valid_out, if_instruction_out}, {1'b0, 32'h0000_0013});
    chk("t4_pc_target", {imem_req, imem_addr}, {1'b1, 32'h200});

    // 5: fetch at the top of the address space, PC+4 wraps
    ex_branch_taken  = 1'b1;
    ex_branch_target = 32'hFFFF_FFFC;
    step(1);
    ex_branch_taken = 1'b0;
    chk("t5_addr", {imem_req, imem_addr}, {1'b1, 32'hFFFF_FFFC});
    grants_issued++;
    sbq.push_back(exp_ld(32'h0000_006F, 32'hFFFF_FFFC, 32'h0));
    step(2);
    chk("t5_ifid_wrap", ifid(), exp_ld(32'h0000_006F, 32'hFFFF_FFFC, 32'h0));
    chk("t5_next_addr", {imem_req, imem_addr}, {1'b1, 32'h0});

    // 6: asynchronous reset while a response is outstanding
`ifdef IFETCH_PERF_CNT_EN
    chk("t6_perf_pre", {64'd0, perf_fetch_cnt, perf_stall_cnt}, {64'd0, 32'd6, 32'd4});
`endif
    lat = 2;
    grants_issued++;
    step(1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_async_ifid", ifid(), {32'd0, 32'h0000_0013, 32'h0, 32'h4});
    chk("t6_async_req", 128'(imem_req), 128'd0);
`ifdef IFETCH_PERF_CNT_EN
    chk("t6_perf_rst", {64'd0, perf_fetch_cnt, perf_stall_cnt}, 128'd0);
`endif
    step(2);
    rst = 1'b1;
    lat = 1;
    grants_issued++;
    sbq.push_back(exp_ld(32'h0050_0093, 32'h0, 32'h4));
    #2;
    chk("t6_post_addr", {imem_req, imem_addr}, {1'b1, 32'h0});
    step(4);

    chk("sb_drained", 128'(sbq.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
